icache_loader: RTL and testbench



---
 rtl/icache_loader.sv | 113 +++++++++++
 tb/tb_icache_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_loader.sv
// icache_loader: packs a little-endian byte stream into 32-bit instructions
// and writes them to consecutive icache entries starting at entry 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; all strobes low
// S_RECV  | accepting bytes (rx_ready=1) until four bytes form a word
// S_WRITE | one-cycle icache write of the assembled word
// S_DONE  | one-cycle done pulse after the final word, then back to idle
module icache_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    input  logic              i_abort,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_byte,
    output logic              o_rx_ready,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Full cache depth; also the value substituted for out-of-range lengths.
    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_len_q;
    logic [ADDR_W:0]   r_word_cnt;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_buffer;
    logic [DATA_W-1:0] r_write_data;

    logic [ADDR_W:0]   w_len_eff;
    logic              w_last_word;

    // Length 0 or anything beyond the cache depth loads the whole cache.
    assign w_len_eff   = ((i_len == '0) || (i_len > FULL_LEN)) ? FULL_LEN : i_len;
    assign w_last_word = (r_word_cnt == (r_len_q - 1'b1));

    // Sequencer: byte packing, word counting and state transitions; abort wins everywhere.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state      <= S_IDLE;
            r_len_q      <= '0;
            r_word_cnt   <= '0;
            r_byte_cnt   <= '0;
            r_buffer     <= '0;
            r_write_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_len_q    <= w_len_eff;
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
                        r_state    <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (i_rx_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_buffer[7:0]   <= i_rx_byte;
                            2'd1: r_buffer[15:8]  <= i_rx_byte;
                            2'd2: r_buffer[23:16] <= i_rx_byte;
                            default: begin
                                // Capture the whole word now so write_data stays
                                // stable while the next word is being received.
                                r_write_data <= {i_rx_byte, r_buffer};
                                r_state      <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_last_word) begin
                        r_state <= S_DONE;
                    end else begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        r_state    <= S_RECV;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from state; abort suppresses any strobe in its cycle.
    assign o_rx_ready   = (r_state == S_RECV)  && !i_abort;
    assign o_write      = (r_state == S_WRITE) && !i_abort;
    assign o_done       = (r_state == S_DONE)  && !i_abort;
    assign o_busy       = (r_state != S_IDLE);
    assign o_write_addr = r_word_cnt[ADDR_W-1:0];
    assign o_write_data = r_write_data;

endmodule

// File: tb/tb_icache_loader.sv
// Testbench for icache_loader: table of load lengths with random byte streams
// checked against a word-packing reference model, plus directed corner cases.
module tb_icache_loader;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [5:0]  len;
    logic        abort;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        busy;
    logic        done;

    icache_loader #(.ADDR_W(5), .DATA_W(32)) dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_start      (start),
        .i_len        (len),
        .i_abort      (abort),
        .i_rx_valid   (rx_valid),
        .i_rx_byte    (rx_byte),
        .o_rx_ready   (rx_ready),
        .o_write      (write),
        .o_write_addr (write_addr),
        .o_write_data (write_data),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    bit spam_en   = 1'b0;

    logic [7:0]  stim_q[$];
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];

    typedef struct {
        logic [5:0] len;
        int         eff;
        int         gap_max;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: word i is bytes 4i..4i+3 with the first byte least significant.
    function automatic logic [31:0] model_word(input int i);
        logic [31:0] w = 0;
        for (int k = 0; k < 4; k++) w += 32'(stim_q[4*i+k]) << (8*k);
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every write and done pulse; strobes must never coincide with rx_ready.
    always @(negedge clk) begin
        if (write) begin
            wa_q.push_back(int'(write_addr));
            wd_q.push_back(write_data);
            wc_q.push_back(cyc);
            chk("rdy_during_write", rx_ready, 0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("rdy_during_done", rx_ready, 0);
        end
    end

    // Random start pulses while a load is in flight.
    always @(posedge clk) begin
        if (spam_en) begin
            #2;
            if (spam_en) start = 1'($urandom_range(0, 1));
        end
    end

    task automatic clear_mon();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        done_cnt = 0;
        done_cyc = 0;
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
    endtask

    task automatic do_start(input logic [5:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    // Offer stim_q[first..first+n-1] one at a time, each held until accepted.
    task automatic send_bytes(input int first, input int n, input int gap_max, input bit hold_after);
        for (int i = first; i < first + n; i++) begin
            int gaps = $urandom_range(0, gap_max);
            bit acc  = 1'b0;
            int tmo  = 0;
            repeat (gaps) begin
                rx_valid = 1'b0;
                rx_byte  = 8'($urandom);
                @(posedge clk); #1;
            end
            rx_valid = 1'b1;
            rx_byte  = stim_q[i];
            while (!acc && tmo < 50) begin
                @(negedge clk);
                acc = rx_ready;
                @(posedge clk); #1;
                tmo++;
            end
            if (!acc) begin
                chk("byte_accept_timeout", 0, 1);
                break;
            end
        end
        rx_valid = hold_after;
        rx_byte  = 8'hEE;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic verify_load(input int eff);
        chk("num_writes", wa_q.size(), eff);
        for (int i = 0; i < wa_q.size() && i < eff; i++) begin
            chk($sformatf("addr[%0d]", i), wa_q[i], i);
            chk($sformatf("data[%0d]", i), wd_q[i], model_word(i));
        end
        chk("done_count", done_cnt, 1);
        if (wc_q.size() > 0) chk("done_after_last_write", done_cyc - wc_q[$], 1);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic run_load(input logic [5:0] l, input int eff, input int gap_max,
                            input bit hold, input bit spam);
        clear_mon();
        do_start(l);
        spam_en = spam;
        send_bytes(0, 4*eff, gap_max, hold);
        spam_en  = 1'b0;
        start    = 1'b0;
        wait_done();
        repeat (2) begin @(posedge clk); #1; end
        rx_valid = 1'b0;
        verify_load(eff);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{len: 6'd1,  eff: 1,  gap_max: 0};
        tbl[1] = '{len: 6'd3,  eff: 3,  gap_max: 2};
        tbl[2] = '{len: 6'd0,  eff: 32, gap_max: 3};
        tbl[3] = '{len: 6'd33, eff: 32, gap_max: 1};
        tbl[4] = '{len: 6'd63, eff: 32, gap_max: 0};
        tbl[5] = '{len: 6'd2,  eff: 2,  gap_max: 4};
        tbl[6] = '{len: 6'd32, eff: 32, gap_max: 2};
        tbl[7] = '{len: 6'd7,  eff: 7,  gap_max: 3};

        nrst = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        rx_valid = 1'b0; rx_byte = '0;
        #3;
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_write", write, 0);
        chk("rst_write_addr", write_addr, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        nrst = 1'b1;

        // Single word, back-to-back bytes.
        stim_q = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_load(6'd1, 1, 0, 1'b0, 1'b0);
        if (wd_q.size() > 0) chk("len1_data_literal", wd_q[0], 32'h0000_0013);

        // Three words, continuous stream: writes exactly 5 cycles apart.
        stim_q.delete();
        for (int i = 1; i <= 12; i++) stim_q.push_back(8'(i));
        run_load(6'd3, 3, 0, 1'b0, 1'b0);
        if (wd_q.size() == 3) begin
            chk("len3_word2_literal", wd_q[2], 32'h0C0B_0A09);
            chk("len3_spacing01", wc_q[1] - wc_q[0], 5);
            chk("len3_spacing12", wc_q[2] - wc_q[1], 5);
        end

        // Table of lengths with random data and random valid gaps.
        for (int v = 0; v < 8; v++) begin
            fill_random(4 * tbl[v].eff);
            run_load(tbl[v].len, tbl[v].eff, tbl[v].gap_max, 1'b0, 1'b0);
        end

        // Abort after 6 bytes of a 4-word load.
        clear_mon();
        fill_random(16);
        do_start(6'd4);
        send_bytes(0, 6, 0, 1'b0);
        rx_valid = 1'b1;
        rx_byte  = stim_q[6];
        abort    = 1'b1;
        @(negedge clk);
        chk("abort_rx_ready", rx_ready, 0);
        chk("abort_no_write", write, 0);
        @(posedge clk); #1;
        abort    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_num_writes", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            chk("abort_addr0", wa_q[0], 0);
            chk("abort_data0", wd_q[0], model_word(0));
        end
        chk("abort_no_done", done_cnt, 0);
        fill_random(4);
        run_load(6'd1, 1, 0, 1'b0, 1'b0);

        // Reset mid-word, then a clean load must not see the stale bytes.
        clear_mon();
        fill_random(8);
        do_start(6'd2);
        send_bytes(0, 2, 0, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        chk("mid_rst_rx_ready", rx_ready, 0);
        chk("mid_rst_write", write, 0);
        chk("mid_rst_write_addr", write_addr, 0);
        chk("mid_rst_write_data", write_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        chk("mid_rst_no_writes", wa_q.size(), 0);
        fill_random(4);
        run_load(6'd1, 1, 0, 1'b0, 1'b0);

        // Start spammed during a 2-word load, rx_valid held through WRITE/DONE.
        fill_random(8);
        run_load(6'd2, 2, 1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("spam_still_idle", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
